spike_threshold_unit: RTL and testbench



---
 rtl/snn_float_pkg.sv | 22 ++
 rtl/fp32_ge_compare.sv | 28 ++
 rtl/spike_threshold_unit.sv | 147 ++++++++++++++
 tb/tb_spike_threshold_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_float_pkg.sv
// Shared single-precision float field layout and spike-threshold FSM encoding.
package snn_float_pkg;
  localparam int FP_W        = 32;
  localparam int FP_EXP_W    = 8;
  localparam int FP_MANT_W   = 23;
  localparam int FP_SIGN_BIT = 31;
  localparam int FP_EXP_LSB  = 23;

  localparam logic [FP_W-1:0]     FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0]     FP_NEG_ZERO = 32'h8000_0000;
  localparam logic [FP_EXP_W-1:0] FP_EXP_NAN  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  function automatic logic fp_is_nan(input logic [FP_W-1:0] f);
    return (f[FP_EXP_LSB +: FP_EXP_W] == FP_EXP_NAN) && (f[FP_MANT_W-1:0] != '0);
  endfunction
endpackage

// File: rtl/fp32_ge_compare.sv
// Combinational a >= b on IEEE-754 singles by sign/magnitude ordering; +0 == -0,
// denormals compared raw, nan flags either operand being NaN (ge forced low).
module fp32_ge_compare
  import snn_float_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic            ge,
  output logic            nan
);
  logic [FP_W-2:0] a_mag, b_mag;
  logic            a_sgn, b_sgn;

  always_comb begin
    a_mag = a[FP_W-2:0];
    b_mag = b[FP_W-2:0];
    a_sgn = a[FP_SIGN_BIT];
    b_sgn = b[FP_SIGN_BIT];
    nan   = fp_is_nan(a) || fp_is_nan(b);
    ge    = 1'b0;
    if (nan)                              ge = 1'b0;
    else if (a_mag == '0 && b_mag == '0)  ge = 1'b1;
    else if (!a_sgn && b_sgn)             ge = 1'b1;
    else if (a_sgn && !b_sgn)             ge = 1'b0;
    else if (!a_sgn)                      ge = (a_mag >= b_mag);
    else                                  ge = (a_mag <= b_mag);
  end
endmodule

// File: rtl/spike_threshold_unit.sv
// Threshold/refractory stage after potential decay: IDLE->EVAL->HOLD per sample.
// Optional SPIKE_COUNT_EN adds per-neuron 16-bit saturating spike counters.
module spike_threshold_unit
  import snn_float_pkg::*;
#(
  parameter int               NUM_NEURONS   = 4,
  parameter int               ID_W          = 2,
  parameter int               REF_W         = 4,
  parameter logic [FP_W-1:0]  DEF_THRESHOLD = 32'h41F0_0000,
  parameter logic [FP_W-1:0]  DEF_V_RESET   = 32'h0000_0000
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [FP_W-1:0]  cfg_threshold,
  input  logic [FP_W-1:0]  cfg_v_reset,
  input  logic [REF_W-1:0] cfg_refractory,
  input  logic             timestep_tick,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ID_W-1:0]  in_neuron_id,
  input  logic [FP_W-1:0]  in_potential,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_neuron_id,
  output logic [FP_W-1:0]  out_potential,
  output logic             out_spike
`ifdef SPIKE_COUNT_EN
  ,
  input  logic [ID_W-1:0]  cnt_sel,
  input  logic             cnt_clr,
  output logic [15:0]      cnt_value
`endif
);
  state_t state, next_state;

  logic [FP_W-1:0]  thr_q, vr_q;
  logic [REF_W-1:0] ref_q;
  logic [ID_W-1:0]  lat_id;
  logic [FP_W-1:0]  lat_pot, lat_thr, lat_vr;
  logic [REF_W-1:0] lat_ref;
  logic [REF_W-1:0] ref_cnt [NUM_NEURONS];

  logic ge, nan, refr, spike, load, accept;

  fp32_ge_compare u_cmp (.a(lat_pot), .b(lat_thr), .ge(ge), .nan(nan));

  assign accept = (state == ST_IDLE) && in_valid;
  assign refr   = (ref_cnt[lat_id] != '0);
  assign spike  = ge && !nan && !refr;
  assign load   = (state == ST_EVAL) && spike;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = ST_EVAL;
      end
      ST_EVAL: next_state = ST_HOLD;
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // cfg writes land in the live registers; the sample snapshots them at accept.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      thr_q   <= DEF_THRESHOLD;
      vr_q    <= DEF_V_RESET;
      ref_q   <= '0;
      lat_id  <= '0;
      lat_pot <= FP_POS_ZERO;
      lat_thr <= DEF_THRESHOLD;
      lat_vr  <= DEF_V_RESET;
      lat_ref <= '0;
    end else begin
      if (cfg_we) begin
        thr_q <= cfg_threshold;
        vr_q  <= cfg_v_reset;
        ref_q <= cfg_refractory;
      end
      if (accept) begin
        lat_id  <= in_neuron_id;
        lat_pot <= in_potential;
        lat_thr <= thr_q;
        lat_vr  <= vr_q;
        lat_ref <= ref_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      out_spike     <= 1'b0;
      out_neuron_id <= '0;
      out_potential <= FP_POS_ZERO;
    end else if (state == ST_EVAL) begin
      out_spike     <= spike;
      out_neuron_id <= lat_id;
      out_potential <= (nan || refr || spike) ? lat_vr : lat_pot;
    end
  end

  // A spike reload beats the tick decrement for the same neuron.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) ref_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (load && lat_id == ID_W'(i))
          ref_cnt[i] <= lat_ref;
        else if (timestep_tick && ref_cnt[i] != '0)
          ref_cnt[i] <= ref_cnt[i] - REF_W'(1);
      end
    end
  end

`ifdef SPIKE_COUNT_EN
  logic [15:0] spk_cnt [NUM_NEURONS];

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) spk_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (cnt_clr && cnt_sel == ID_W'(i))
          spk_cnt[i] <= '0;
        else if (load && lat_id == ID_W'(i) && spk_cnt[i] != 16'hFFFF)
          spk_cnt[i] <= spk_cnt[i] + 16'd1;
      end
    end
  end

  assign cnt_value = spk_cnt[cnt_sel];
`endif
endmodule

// File: tb/tb_spike_threshold_unit.sv
// Directed bench for spike_threshold_unit: compare, refractory, backpressure, cfg timing, reset.
module tb_spike_threshold_unit;
  logic        CLK = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [31:0] cfg_threshold, cfg_v_reset;
  logic [3:0]  cfg_refractory;
  logic        timestep_tick;
  logic        in_valid, in_ready;
  logic [1:0]  in_neuron_id;
  logic [31:0] in_potential;
  logic        out_valid, out_ready;
  logic [1:0]  out_neuron_id;
  logic [31:0] out_potential;
  logic        out_spike;
`ifdef SPIKE_COUNT_EN
  logic [1:0]  cnt_sel = '0;
  logic        cnt_clr = 1'b0;
  logic [15:0] cnt_value;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  spike_threshold_unit dut (
    .CLK(CLK), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_threshold(cfg_threshold),
    .cfg_v_reset(cfg_v_reset), .cfg_refractory(cfg_refractory), .timestep_tick(timestep_tick),
    .in_valid(in_valid), .in_ready(in_ready), .in_neuron_id(in_neuron_id),
    .in_potential(in_potential), .out_valid(out_valid), .out_ready(out_ready),
    .out_neuron_id(out_neuron_id), .out_potential(out_potential), .out_spike(out_spike)
`ifdef SPIKE_COUNT_EN
    , .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_value(cnt_value)
`endif
  );

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic set_cfg(input logic [31:0] thr, input logic [31:0] vr, input logic [3:0] rf);
    cfg_we = 1'b1; cfg_threshold = thr; cfg_v_reset = vr; cfg_refractory = rf;
    @(posedge CLK); #1;
    cfg_we = 1'b0;
  endtask

  task automatic tick();
    timestep_tick = 1'b1;
    @(posedge CLK); #1;
    timestep_tick = 1'b0;
  endtask

  // Stimulus only: presents one sample, returns what the DUT produced and the
  // number of edges between the accept edge and out_valid.
  task automatic run(input logic [1:0] id, input logic [31:0] pot, output logic sp,
                     output logic [31:0] op, output logic [1:0] oid, output int lat);
    in_valid = 1'b1; in_neuron_id = id; in_potential = pot; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin @(posedge CLK); #1; lat++; end
    sp = out_spike; op = out_potential; oid = out_neuron_id;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_spike !== 1'b0) begin errors++; $display("FAIL reset_out_spike: got %b exp 0", out_spike); end
    checks++; if (out_neuron_id !== 2'd0) begin errors++; $display("FAIL reset_out_id: got %0d exp 0", out_neuron_id); end
    checks++; if (out_potential !== 32'h0) begin errors++; $display("FAIL reset_out_pot: got %h exp 00000000", out_potential); end
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_below();
    logic sp; logic [31:0] op; logic [1:0] oid; int lat;
    run(2'd0, 32'h41DED852, sp, op, oid, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL below_latency: got %0d exp 1", lat); end
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL below_spike: got %b exp 0", sp); end
    checks++; if (op !== 32'h41DED852) begin errors++; $display("FAIL below_pot: got %h exp 41ded852", op); end
    checks++; if (oid !== 2'd0) begin errors++; $display("FAIL below_id: got %0d exp 0", oid); end
  endtask

  task automatic test_refractory();
    logic sp; logic [31:0] op; logic [1:0] oid; int lat;
    set_cfg(32'h41F00000, 32'h0, 4'd2);
    run(2'd1, 32'h42000000, sp, op, oid, lat);
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL ref_first_spike: got %b exp 1", sp); end
    checks++; if (op !== 32'h0) begin errors++; $display("FAIL ref_first_pot: got %h exp 00000000", op); end
    checks++; if (oid !== 2'd1) begin errors++; $display("FAIL ref_first_id: got %0d exp 1", oid); end
    run(2'd1, 32'h42000000, sp, op, oid, lat);
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL ref_blocked_spike: got %b exp 0", sp); end
    checks++; if (op !== 32'h0) begin errors++; $display("FAIL ref_blocked_pot: got %h exp 00000000", op); end
    tick();
    run(2'd1, 32'h42000000, sp, op, oid, lat);
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL ref_one_tick_spike: got %b exp 0", sp); end
    tick();
    run(2'd1, 32'h42000000, sp, op, oid, lat);
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL ref_two_tick_spike: got %b exp 1", sp); end
  endtask

  task automatic test_compare();
    logic sp; logic [31:0] op; logic [1:0] oid; int lat;
    set_cfg(32'h41F00000, 32'h3F800000, 4'd0);
    run(2'd2, 32'h41F00000, sp, op, oid, lat);
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL cmp_equal_spike: got %b exp 1", sp); end
    checks++; if (op !== 32'h3F800000) begin errors++; $display("FAIL cmp_equal_pot: got %h exp 3f800000", op); end
    run(2'd2, 32'hC2000000, sp, op, oid, lat);
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL cmp_neg32_spike: got %b exp 0", sp); end
    checks++; if (op !== 32'hC2000000) begin errors++; $display("FAIL cmp_neg32_pot: got %h exp c2000000", op); end
    set_cfg(32'h00000000, 32'h3F800000, 4'd0);
    run(2'd2, 32'h80000000, sp, op, oid, lat);
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL cmp_negzero_spike: got %b exp 1", sp); end
    run(2'd2, 32'hBF800000, sp, op, oid, lat);
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL cmp_neg1_spike: got %b exp 0", sp); end
    checks++; if (op !== 32'hBF800000) begin errors++; $display("FAIL cmp_neg1_pot: got %h exp bf800000", op); end
    run(2'd2, 32'h00000001, sp, op, oid, lat);
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL cmp_denorm_spike: got %b exp 1", sp); end
    set_cfg(32'hC1000000, 32'h3F800000, 4'd0);
    run(2'd2, 32'hC0000000, sp, op, oid, lat);
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL cmp_neg2_vs_neg8: got %b exp 1", sp); end
    run(2'd2, 32'hC1800000, sp, op, oid, lat);
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL cmp_neg16_vs_neg8: got %b exp 0", sp); end
  endtask

  task automatic test_nan();
    logic sp; logic [31:0] op; logic [1:0] oid; int lat;
    set_cfg(32'h41F00000, 32'h3F800000, 4'd0);
    run(2'd3, 32'h7FC00000, sp, op, oid, lat);
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL nan_spike: got %b exp 0", sp); end
    checks++; if (op !== 32'h3F800000) begin errors++; $display("FAIL nan_pot: got %h exp 3f800000", op); end
    run(2'd3, 32'h7F800000, sp, op, oid, lat);
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL inf_spike: got %b exp 1", sp); end
  endtask

  task automatic test_cfg_timing();
    logic sp; logic [31:0] op; logic [1:0] oid; int lat;
    // cfg write coincides with accept: this sample still sees thr=30, vr=1.0
    in_valid = 1'b1; in_neuron_id = 2'd3; in_potential = 32'h42000000; out_ready = 1'b1;
    cfg_we = 1'b1; cfg_threshold = 32'h7F000000; cfg_v_reset = 32'h40000000; cfg_refractory = 4'd0;
    @(posedge CLK); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin @(posedge CLK); #1; lat++; end
    checks++; if (out_spike !== 1'b1) begin errors++; $display("FAIL cfgacc_spike: got %b exp 1", out_spike); end
    checks++; if (out_potential !== 32'h3F800000) begin errors++; $display("FAIL cfgacc_pot: got %h exp 3f800000", out_potential); end
    @(posedge CLK); #1;
    run(2'd3, 32'h42000000, sp, op, oid, lat);
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL cfgnext_spike: got %b exp 0", sp); end
    checks++; if (op !== 32'h42000000) begin errors++; $display("FAIL cfgnext_pot: got %h exp 42000000", op); end
  endtask

  task automatic test_backpressure();
    logic sp; logic [31:0] op; logic [1:0] oid; int lat;
    set_cfg(32'h41F00000, 32'h0, 4'd0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_neuron_id = 2'd3; in_potential = 32'h41000000;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(posedge CLK); #1;
    for (int i = 0; i < 5; i++) begin
      cfg_we = (i == 0); cfg_threshold = 32'h0; cfg_v_reset = 32'h0; cfg_refractory = 4'd0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b exp 1", i, out_valid); end
      checks++; if (out_potential !== 32'h41000000) begin errors++; $display("FAIL hold_pot[%0d]: got %h exp 41000000", i, out_potential); end
      checks++; if (out_spike !== 1'b0) begin errors++; $display("FAIL hold_spike[%0d]: got %b exp 0", i, out_spike); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b exp 0", i, in_ready); end
      @(posedge CLK); #1;
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b exp 1", in_ready); end
    run(2'd3, 32'h41000000, sp, op, oid, lat);
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL hold_cfg_applied: got %b exp 1", sp); end
  endtask

  task automatic test_tick_load();
    logic sp; logic [31:0] op; logic [1:0] oid; int lat;
    set_cfg(32'h41F00000, 32'h0, 4'd1);
    run(2'd0, 32'h42000000, sp, op, oid, lat);
    set_cfg(32'h41F00000, 32'h0, 4'd3);
    // tick lands on the EVAL edge of a neuron-2 spike
    in_valid = 1'b1; in_neuron_id = 2'd2; in_potential = 32'h42000000; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; timestep_tick = 1'b1;
    @(posedge CLK); #1;
    timestep_tick = 1'b0;
    checks++; if (out_spike !== 1'b1) begin errors++; $display("FAIL tickload_spike: got %b exp 1", out_spike); end
    @(posedge CLK); #1;
    run(2'd0, 32'h42000000, sp, op, oid, lat);
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL tickload_other_dec: got %b exp 1", sp); end
    tick(); tick();
    run(2'd2, 32'h42000000, sp, op, oid, lat);
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL tickload_still_ref: got %b exp 0", sp); end
    tick();
    run(2'd2, 32'h42000000, sp, op, oid, lat);
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL tickload_expired: got %b exp 1", sp); end
  endtask

  task automatic test_async_reset();
    logic sp; logic [31:0] op; logic [1:0] oid; int lat;
    set_cfg(32'h41F00000, 32'h0, 4'd3);
    run(2'd1, 32'h42000000, sp, op, oid, lat);
    set_cfg(32'h42C80000, 32'h3F800000, 4'd5);
    in_valid = 1'b1; in_neuron_id = 2'd1; in_potential = 32'h42000000; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL arst_pre_in_ready: got %b exp 0", in_ready); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b exp 0", out_valid); end
    @(posedge CLK); #1;
    rst_n = 1'b1;
    @(posedge CLK); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_result_lost: got %b exp 0", out_valid); end
    run(2'd1, 32'h41F00000, sp, op, oid, lat);
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL arst_defaults_spike: got %b exp 1", sp); end
    checks++; if (op !== 32'h0) begin errors++; $display("FAIL arst_defaults_vreset: got %h exp 00000000", op); end
    run(2'd1, 32'h41F00000, sp, op, oid, lat);
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL arst_ref_period_zero: got %b exp 1", sp); end
  endtask

  initial begin
    cfg_we = 1'b0; cfg_threshold = '0; cfg_v_reset = '0; cfg_refractory = '0;
    timestep_tick = 1'b0; in_valid = 1'b0; in_neuron_id = '0; in_potential = '0;
    out_ready = 1'b1;
    test_reset();
    test_below();
    test_refractory();
    test_compare();
    test_nan();
    test_cfg_timing();
    test_backpressure();
    test_tick_load();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
